// File: rtl/jtbubl_gfx_cache_pkg.sv
// Shared definitions for the graphics ROM read cache: default geometry,
// derived index/tag widths and the controller state encoding.
package jtbubl_gfx_pkg;

   localparam int GFX_AW         = 18;
   localparam int GFX_DW         = 32;
   localparam int GFX_LINES_LOG2 = 4;
   localparam int GFX_LINES      = 1 << GFX_LINES_LOG2;
   localparam int GFX_TAG_W      = GFX_AW - GFX_LINES_LOG2;

   typedef enum logic {
      ST_LOOKUP = 1'b0,
      ST_FETCH  = 1'b1
   } state_t;

endpackage

// File: rtl/jtbubl_gfx_cache_ram.sv
// Data array of the cache: one write port used by SDRAM fills and one
// asynchronous read port indexed by the client address, so it maps onto
// distributed LUT-RAM.
module jtbubl_cache_ram #(
   parameter int DW = 32,
   parameter int IW = 4
) (
   input  logic          clk,
   input  logic          we,
   input  logic [IW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic [IW-1:0] rd_addr,
   output logic [DW-1:0] rd_data
);

   logic [DW-1:0] mem [1<<IW];

   // Fill write; storage itself has no reset.
   // NOTE: memories are not reset -- the valid bits in the top gate every
   // read, and a reset port would prevent LUT-RAM inference.
   always_ff @(posedge clk) begin
      if (we) mem[wr_addr] <= wr_data;
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/jtbubl_gfx_cache.sv
// Direct-mapped read cache between the video graphics ROM port and the
// SDRAM graphics slot. Hits answer in one cycle; misses fetch one word.
// Tags and valid bits live in flops so flush clears everything at once.
module jtbubl_gfx_cache
   import jtbubl_gfx_pkg::*;
#(
   parameter int AW         = GFX_AW,
   parameter int DW         = GFX_DW,
   parameter int LINES_LOG2 = GFX_LINES_LOG2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic [AW-1:0] cl_addr,
   input  logic          cl_cs,
   output logic [DW-1:0] cl_data,
   output logic          cl_ok,
   output logic [AW-1:0] sd_addr,
   output logic          sd_cs,
   input  logic [DW-1:0] sd_data,
   input  logic          sd_ok
);

   localparam int IW    = LINES_LOG2;
   localparam int TW    = AW - LINES_LOG2;
   localparam int LINES = 1 << LINES_LOG2;

   state_t          state, state_nx;
   logic [LINES-1:0] valid;
   logic [TW-1:0]   tags [LINES];
   logic            first;     // first FETCH cycle: sd_ok may be stale
   logic            flushed;   // flush seen during the current fetch

   logic [IW-1:0]   cl_idx, sd_idx;
   logic [TW-1:0]   cl_tag;
   logic [DW-1:0]   rd_data;
   logic            hit, hit_take, start_fetch, fill;

   assign cl_idx = cl_addr[IW-1:0];
   assign cl_tag = cl_addr[AW-1:IW];
   assign sd_idx = sd_addr[IW-1:0];
   assign hit    = valid[cl_idx] && (tags[cl_idx] == cl_tag);

   jtbubl_cache_ram #(.DW(DW), .IW(IW)) u_ram (
      .clk     (clk),
      .we      (fill),
      .wr_addr (sd_idx),
      .wr_data (sd_data),
      .rd_addr (cl_idx),
      .rd_data (rd_data)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_LOOKUP;
      else        state <= state_nx;
   end

   // Next state and per-cycle control strobes.
   // NOTE: every always_comb output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_nx    = state;
      hit_take    = 1'b0;
      start_fetch = 1'b0;
      fill        = 1'b0;
      case (state)
         ST_LOOKUP: begin
            if (!flush && cl_cs) begin
               if (hit) begin
                  hit_take = 1'b1;
               end else begin
                  start_fetch = 1'b1;
                  state_nx    = ST_FETCH;
               end
            end
         end
         ST_FETCH: begin
            if (!first && sd_ok) begin
               fill     = 1'b1;
               state_nx = ST_LOOKUP;
            end
         end
         default: state_nx = ST_LOOKUP;
      endcase
   end

   // Registered client outputs and SDRAM request.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cl_ok   <= 1'b0;
         cl_data <= '0;
         sd_addr <= '0;
         sd_cs   <= 1'b0;
         first   <= 1'b0;
         flushed <= 1'b0;
      end else begin
         cl_ok <= hit_take;
         if (hit_take) cl_data <= rd_data;
         first <= start_fetch;
         if (start_fetch) begin
            sd_addr <= cl_addr;
            sd_cs   <= 1'b1;
            flushed <= 1'b0;
         end else if (state == ST_FETCH && flush) begin
            flushed <= 1'b1;
         end
         if (fill) sd_cs <= 1'b0;
      end
   end

   // Tag and valid flops; a fill touched by flush leaves its line invalid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= '0;
         for (int i = 0; i < LINES; i++) tags[i] <= '0;
      end else begin
         if (fill) tags[sd_idx] <= sd_addr[AW-1:IW];
         if (flush)                  valid         <= '0;
         else if (fill && !flushed)  valid[sd_idx] <= 1'b1;
      end
   end

endmodule

// File: tb/tb_jtbubl_gfx_cache.sv
// Directed bench for jtbubl_gfx_cache with a fixed-latency SDRAM model.
module tb_jtbubl_gfx_cache;

   localparam int AW  = 18;
   localparam int DW  = 32;
   localparam int LAT = 5;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          flush = 1'b0;
   logic [AW-1:0] cl_addr = '0;
   logic          cl_cs = 1'b0;
   logic [DW-1:0] cl_data;
   logic          cl_ok;
   logic [AW-1:0] sd_addr;
   logic          sd_cs;
   logic [DW-1:0] sd_data = '0;
   logic          sd_ok = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;
   int fetch_cnt = 0;
   int sd_cnt    = 0;
   logic          sd_cs_prev = 1'b0;
   logic [AW-1:0] sd_addr_prev = '0;

   always #5 clk = ~clk;

   jtbubl_gfx_cache dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush   (flush),
      .cl_addr (cl_addr),
      .cl_cs   (cl_cs),
      .cl_data (cl_data),
      .cl_ok   (cl_ok),
      .sd_addr (sd_addr),
      .sd_cs   (sd_cs),
      .sd_data (sd_data),
      .sd_ok   (sd_ok)
   );

   function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
      if (a == 18'h00123) return 32'hDEADBEEF;
      return 32'hC0DE_0000 ^ {14'd0, a};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // One clock cycle, observed on the falling edge; also runs the SDRAM
   // model (answers LAT cycles after it first sees sd_cs) and the
   // always-on invariants.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      if (cl_ok) check("ok_data_matches_addr", cl_data, data_of(cl_addr));
      if (sd_cs && sd_cs_prev) check("sd_addr_stable", sd_addr, sd_addr_prev);
      if (sd_cs && !sd_cs_prev) fetch_cnt++;
      sd_cs_prev   = sd_cs;
      sd_addr_prev = sd_addr;
      if (!sd_cs || sd_ok) begin
         sd_cnt = 0;
         sd_ok  = 1'b0;
      end else begin
         sd_cnt++;
         if (sd_cnt > LAT) begin
            sd_ok   = 1'b1;
            sd_data = data_of(sd_addr);
         end
      end
   endtask

   // Present a request, wait (bounded) for cl_ok, check data, latency and
   // how many SDRAM fetches it caused, then release the request.
   task automatic request(input logic [AW-1:0] a, input int exp_cyc,
                          input int exp_fetch, input string tag);
      int n = 0;
      int f0 = fetch_cnt;
      cl_addr = a;
      cl_cs   = 1'b1;
      while (n < 50) begin
         tick();
         n++;
         if (cl_ok) break;
      end
      check({tag, "_ok"}, {31'd0, cl_ok}, 32'd1);
      check({tag, "_data"}, cl_data, data_of(a));
      check({tag, "_cycles"}, n, exp_cyc);
      check({tag, "_fetches"}, fetch_cnt - f0, exp_fetch);
      cl_cs = 1'b0;
      tick();
   endtask

   initial begin
      int n;
      int f0;
      // Reset state
      tick(); tick();
      check("rst_cl_ok", {31'd0, cl_ok}, 32'd0);
      check("rst_cl_data", cl_data, 32'd0);
      check("rst_sd_cs", {31'd0, sd_cs}, 32'd0);
      check("rst_sd_addr", sd_addr, 32'd0);
      rst_n = 1'b1;
      tick();

      // Cold miss, then hits / conflict misses
      request(18'h00123, 8, 1, "miss_123");
      request(18'h00045, 8, 1, "miss_045");
      request(18'h00123, 1, 0, "hit_123");
      request(18'h00133, 8, 1, "conflict_133");
      request(18'h00123, 8, 1, "evicted_123");
      request(18'h3FFFF, 8, 1, "miss_max");
      request(18'h3FFFF, 1, 0, "hit_max");

      // Address change two cycles into FETCH
      f0 = fetch_cnt;
      cl_addr = 18'h00200;
      cl_cs   = 1'b1;
      tick(); tick();
      cl_addr = 18'h00201;
      tick(); tick();
      check("chg_sd_cs_held", {31'd0, sd_cs}, 32'd1);
      check("chg_sd_addr_orig", sd_addr, 32'h00200);
      n = 0;
      while (n < 50 && !cl_ok) begin tick(); n++; end
      check("chg_ok", {31'd0, cl_ok}, 32'd1);
      check("chg_data", cl_data, data_of(18'h00201));
      check("chg_fetches", fetch_cnt - f0, 2);
      cl_cs = 1'b0;
      tick();
      request(18'h00200, 1, 0, "chg_orig_filled");

      // Flush pulse during a fetch: fill must not become valid
      cl_addr = 18'h00300;
      cl_cs   = 1'b1;
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      cl_cs = 1'b0;
      n = 0;
      while (n < 50 && sd_cs) begin tick(); n++; end
      check("flush_fetch_done", {31'd0, sd_cs}, 32'd0);
      tick(); tick();
      check("flush_no_ok", {31'd0, cl_ok}, 32'd0);

      // No new fetch while flush held high
      flush   = 1'b1;
      cl_addr = 18'h00123;
      cl_cs   = 1'b1;
      tick(); tick(); tick();
      check("flush_hold_sd_cs", {31'd0, sd_cs}, 32'd0);
      check("flush_hold_ok", {31'd0, cl_ok}, 32'd0);
      flush = 1'b0;
      cl_cs = 1'b0;
      tick();
      request(18'h00300, 8, 1, "after_flush_300");
      request(18'h00123, 8, 1, "after_flush_123");

      // Asynchronous reset in the middle of a fetch
      cl_addr = 18'h00045;
      cl_cs   = 1'b1;
      tick(); tick();
      check("pre_rst_sd_cs", {31'd0, sd_cs}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_sd_cs", {31'd0, sd_cs}, 32'd0);
      check("async_rst_cl_ok", {31'd0, cl_ok}, 32'd0);
      check("async_rst_cl_data", cl_data, 32'd0);
      cl_cs = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      request(18'h00123, 8, 1, "post_rst_miss");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
